// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
// Time-multiplexing scan controller for a bank of common-anode seven-segment
// digits sharing one segment bus. One digit is shown per PRESCALE-cycle slot.
// The first BLANK cycles of every slot keep all anodes off to suppress ghosting.
// Display data is double-buffered. A load lands in the shadow register and is
// committed to the active register only at a frame wrap, so a frame never mixes
// old and new digits.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   en         : scan enable; 0 freezes the scan position and blanks the display
//   ld         : one-cycle load strobe for data_in / dp_in
//   data_in    : 4-bit code per digit, nibble i -> digit i (digit 0 = LSD)
//   dp_in      : decimal-point request per digit, 1 = lit
//   lz_en      : leading-zero suppression enable
//   code_out   : code of the current digit, to the shared segment decoder
//   an_n       : active-low anode enables, at most one bit low
//   dp_n       : active-low decimal point, aligned with an_n
//   frame_done : one-cycle pulse after each frame wrap
//   pending    : shadow holds data not yet committed
module ssd_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [3:0]            code_out,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_code_q, shadow_code_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]   active_code_q, active_code_d;
    logic [DIGITS-1:0]     active_dp_q, active_dp_d;
    logic                  pending_q, pending_d;
    logic [3:0]            code_out_q, code_out_d;
    logic [DIGITS-1:0]     an_n_q, an_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  wrap;
    logic [DIGITS-1:0]     supp;
    logic                  zero_run;
    logic [3:0]            sel_code;
    logic                  sel_dp;
    logic                  sel_supp;
    logic                  show;

    // Next-state logic. Outputs are computed from the next cnt/idx/active values,
    // so the registered outputs always match the scan position of the same cycle.
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        active_code_d = active_code_q;
        active_dp_d   = active_dp_q;
        pending_d     = pending_q;
        supp          = '0;
        zero_run      = lz_en;
        sel_code      = 4'd0;
        sel_dp        = 1'b0;
        sel_supp      = 1'b0;
        an_n_d        = '1;

        slot_end = en && (cnt_q == CNT_MAX);
        wrap     = slot_end && (idx_q == IDX_MAX);

        if (en) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (ld) begin
            shadow_code_d = data_in;
            shadow_dp_d   = dp_in;
            pending_d     = 1'b1;
        end

        // A load on the wrap edge bypasses the shadow so the newest data is shown
        // from the very first slot of the new frame.
        if (wrap) begin
            pending_d = 1'b0;
            if (ld) begin
                active_code_d = data_in;
                active_dp_d   = dp_in;
            end else if (pending_q) begin
                active_code_d = shadow_code_q;
                active_dp_d   = shadow_dp_q;
            end
        end

        // Walk down from the most significant digit. A digit is suppressed while
        // every nibble from it upward is zero; digit 0 always stays lit.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (active_code_d[4*k +: 4] == 4'd0);
            supp[k]  = zero_run;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                sel_code = active_code_d[4*i +: 4];
                sel_dp   = active_dp_d[i];
                sel_supp = supp[i];
            end
        end

        show = en && (cnt_d >= BLANK_C) && !sel_supp;

        for (int i = 0; i < DIGITS; i++) begin
            an_n_d[i] = ~(show && (idx_d == IW'(i)));
        end

        dp_n_d       = show ? ~sel_dp : 1'b1;
        code_out_d   = sel_code;
        frame_done_d = wrap;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_code_q <= '0;
            shadow_dp_q   <= '0;
            active_code_q <= '0;
            active_dp_q   <= '0;
            pending_q     <= 1'b0;
            code_out_q    <= 4'd0;
            an_n_q        <= '1;
            dp_n_q        <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            active_code_q <= active_code_d;
            active_dp_q   <= active_dp_d;
            pending_q     <= pending_d;
            code_out_q    <= code_out_d;
            an_n_q        <= an_n_d;
            dp_n_q        <= dp_n_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign code_out   = code_out_q;
    assign an_n       = an_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed testbench for ssd_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK=2.
// Edge numbering: cyc counts rising edges since reset release, and all outputs
// are sampled 1 time unit after the edge. In the initial frames, slot k of frame f
// spans edges 32f+8k .. 32f+8k+7, and the anode is on from +2 to +7.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        ld;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  code_out;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_done;
    logic        pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ssd_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ld         (ld),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .code_out   (code_out),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic runTo(input int target);
        if (target > cyc) applyStimulus(target - cyc);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cyc=%0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] e_an, input logic [3:0] e_code,
                            input logic e_dp, input logic e_fd, input logic e_pend);
        checkOutput({tag, "_an"},   32'(an_n),       32'(e_an));
        checkOutput({tag, "_code"}, 32'(code_out),   32'(e_code));
        checkOutput({tag, "_dp"},   32'(dp_n),       32'(e_dp));
        checkOutput({tag, "_fd"},   32'(frame_done), 32'(e_fd));
        checkOutput({tag, "_pend"}, 32'(pending),    32'(e_pend));
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        ld      = 1'b0;
        data_in = 16'h0000;
        dp_in   = 4'b0000;
        lz_en   = 1'b0;
        $display("[TB] start");

        // Reset state.
        applyStimulus(3);
        checkAll("reset", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc   = 0;
        rst_n = 1'b1;
        en    = 1'b1;

        // Scan rotation with blank active data.
        runTo(1);  checkAll("t1_e1",  4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(2);  checkAll("t1_e2",  4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(7);  checkOutput("t1_e7_an", 32'(an_n), 32'hE);
        runTo(8);  checkOutput("t1_e8_an", 32'(an_n), 32'hF);
        runTo(9);  checkOutput("t1_e9_an", 32'(an_n), 32'hF);
        runTo(10); checkAll("t1_e10", 4'hD, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(18); checkOutput("t1_e18_an", 32'(an_n), 32'hB);
        runTo(26); checkOutput("t1_e26_an", 32'(an_n), 32'h7);
        runTo(31); checkAll("t1_e31", 4'h7, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(32); checkAll("t1_e32", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
        runTo(33); checkOutput("t1_e33_fd", 32'(frame_done), 32'h0);

        // Mid-frame load, committed at the next wrap.
        runTo(40);
        ld = 1'b1; data_in = 16'h1234; dp_in = 4'b0100;
        applyStimulus(1);
        ld = 1'b0;
        checkOutput("t2_e41_pend", 32'(pending), 32'h1);
        runTo(63); checkAll("t2_e63", 4'h7, 4'h0, 1'b1, 1'b0, 1'b1);
        runTo(64); checkAll("t2_e64", 4'hF, 4'h4, 1'b1, 1'b1, 1'b0);
        runTo(66); checkAll("t2_e66", 4'hE, 4'h4, 1'b1, 1'b0, 1'b0);

        // Two loads in one frame; last one wins. Enable suppression.
        runTo(70);
        lz_en = 1'b1;
        ld = 1'b1; data_in = 16'hAAAA; dp_in = 4'b0000;
        applyStimulus(1);
        ld = 1'b0;
        runTo(74); checkAll("t2_e74", 4'hD, 4'h3, 1'b1, 1'b0, 1'b1);
        runTo(80);
        ld = 1'b1; data_in = 16'h0005; dp_in = 4'b0000;
        applyStimulus(1);
        ld = 1'b0;
        runTo(82); checkAll("t2_e82", 4'hB, 4'h2, 1'b0, 1'b0, 1'b1);
        runTo(90); checkAll("t2_e90", 4'h7, 4'h1, 1'b1, 1'b0, 1'b1);
        runTo(96); checkAll("t3_e96", 4'hF, 4'h5, 1'b1, 1'b1, 1'b0);
        runTo(98); checkAll("t3_e98", 4'hE, 4'h5, 1'b1, 1'b0, 1'b0);

        // All-zero load during this frame.
        runTo(100);
        ld = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
        applyStimulus(1);
        ld = 1'b0;
        checkOutput("t3_e101_pend", 32'(pending), 32'h1);
        runTo(106); checkAll("t3_e106", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
        runTo(114); checkOutput("t3_e114_an", 32'(an_n), 32'hF);
        runTo(122); checkOutput("t3_e122_an", 32'(an_n), 32'hF);
        runTo(130); checkAll("t3_e130", 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(138); checkOutput("t3_e138_an", 32'(an_n), 32'hF);

        // Load exactly on the wrap edge (edge 160).
        runTo(159);
        checkOutput("t4_e159_pend", 32'(pending), 32'h0);
        ld = 1'b1; data_in = 16'hBEEF; dp_in = 4'b0000;
        applyStimulus(1);
        ld = 1'b0;
        checkAll("t4_e160", 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        runTo(162); checkAll("t4_e162", 4'hE, 4'hF, 1'b1, 1'b0, 1'b0);
        runTo(170); checkAll("t4_e170", 4'hD, 4'hE, 1'b1, 1'b0, 1'b0);
        runTo(178); checkAll("t4_e178", 4'hB, 4'hE, 1'b1, 1'b0, 1'b0);
        runTo(186); checkAll("t4_e186", 4'h7, 4'hB, 1'b1, 1'b0, 1'b0);

        // Freeze for 20 edges in the middle of digit 2's SHOW window.
        runTo(212); checkAll("t5_e212", 4'hB, 4'hE, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        runTo(213); checkAll("t5_e213", 4'hF, 4'hE, 1'b1, 1'b0, 1'b0);
        runTo(224); checkAll("t5_e224", 4'hF, 4'hE, 1'b1, 1'b0, 1'b0);
        runTo(232); checkOutput("t5_e232_an", 32'(an_n), 32'hF);
        en = 1'b1;
        runTo(233); checkAll("t5_e233", 4'hB, 4'hE, 1'b1, 1'b0, 1'b0);
        runTo(235); checkOutput("t5_e235_an", 32'(an_n), 32'hB);
        runTo(236); checkAll("t5_e236", 4'hF, 4'hB, 1'b1, 1'b0, 1'b0);
        runTo(238); checkOutput("t5_e238_an", 32'(an_n), 32'h7);
        runTo(243); checkAll("t5_e243", 4'h7, 4'hB, 1'b1, 1'b0, 1'b0);
        runTo(244); checkAll("t5_e244", 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);

        // Reset in slot 3 with data pending.
        runTo(250);
        lz_en = 1'b0;
        ld = 1'b1; data_in = 16'h1111; dp_in = 4'b1111;
        applyStimulus(1);
        ld = 1'b0;
        runTo(270); checkAll("t6_e270", 4'h7, 4'hB, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1);
        checkAll("t6_rst", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        runTo(272); checkOutput("t6_e272_an", 32'(an_n), 32'hF);
        runTo(273); checkAll("t6_e273", 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(281); checkAll("t6_e281", 4'hD, 4'h0, 1'b1, 1'b0, 1'b0);
        runTo(303); checkAll("t6_e303", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
        runTo(305); checkAll("t6_e305", 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
